// File: rtl/car_motion_controller_pkg.sv
// Shared constants, FSM encoding and position arithmetic for the car motion controller.
// Optional lane direction flipping on wrap is enabled by defining CAR_MOTION_LANE_FLIP_EN.
package car_motion_controller_pkg;

    localparam int H_VISIBLE_AREA = 640;
    localparam int V_VISIBLE_AREA = 480;
    localparam int STEP_PX        = 2;

    localparam logic [3:0]  LANE_DIR    = 4'b0101;
    localparam logic [9:0]  V_TICK_LINE = 10'(V_VISIBLE_AREA);
    localparam logic [10:0] H_W         = 11'(H_VISIBLE_AREA);
    localparam logic [10:0] STEP_W      = 11'(STEP_PX);

    // Lane base periods in frames per step, lanes 0..3
    localparam logic [2:0] BASE_PERIOD_L0 = 3'd2;
    localparam logic [2:0] BASE_PERIOD_L1 = 3'd3;
    localparam logic [2:0] BASE_PERIOD_L2 = 3'd4;
    localparam logic [2:0] BASE_PERIOD_L3 = 3'd6;

    // Lane mapping: lane 0 = C1/C5, lane 1 = C2/C6, lane 2 = C3, lane 3 = C4
    localparam logic [9:0] C1_INIT = 10'd0;
    localparam logic [9:0] C5_INIT = 10'd320;
    localparam logic [9:0] C2_INIT = 10'd64;
    localparam logic [9:0] C6_INIT = 10'd384;
    localparam logic [9:0] C3_INIT = 10'd128;
    localparam logic [9:0] C4_INIT = 10'd256;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    function automatic logic [2:0] lane_period(input logic [2:0] base, input logic [1:0] level);
        logic [2:0] diff;
        diff = base - {1'b0, level};
        return (base > {1'b0, level}) ? diff : 3'd1;
    endfunction

    function automatic logic crosses_edge(input logic [9:0] x, input logic right);
        logic [10:0] s;
        s = {1'b0, x} + STEP_W;
        return right ? (s >= H_W) : ({1'b0, x} < STEP_W);
    endfunction

    function automatic logic [9:0] next_x(input logic [9:0] x, input logic right);
        logic [10:0] x11;
        logic [10:0] s;
        x11 = {1'b0, x};
        if (right) begin
            s = x11 + STEP_W;
            if (s >= H_W) s = s - H_W;
        end else if (x11 < STEP_W) begin
            s = x11 + H_W - STEP_W;
        end else begin
            s = x11 - STEP_W;
        end
        return s[9:0];
    endfunction

endpackage

// File: rtl/car_motion_controller_if.sv
// Bundle of raster inputs and car position outputs between the controller and the sprite stage.
// Handshake: none; raster counters are sampled every clock, outputs are registered and always valid.
interface car_motion_controller_if;
    import car_motion_controller_pkg::*;

    logic [9:0] i_H_Counter;
    logic [9:0] i_V_Counter;
    logic [1:0] i_Level;
    logic       i_Pause;
    logic       o_Frame_Tick;
    logic [9:0] o_Car_1X;
    logic [9:0] o_Car_2X;
    logic [9:0] o_Car_3X;
    logic [9:0] o_Car_4X;
    logic [9:0] o_Car_5X;
    logic [9:0] o_Car_6X;
    logic [3:0] o_Reverse;
    state_t     o_State;

    modport master (
        output i_H_Counter, i_V_Counter, i_Level, i_Pause,
        input  o_Frame_Tick, o_Car_1X, o_Car_2X, o_Car_3X, o_Car_4X, o_Car_5X, o_Car_6X,
        input  o_Reverse, o_State
    );

    modport slave (
        input  i_H_Counter, i_V_Counter, i_Level, i_Pause,
        output o_Frame_Tick, o_Car_1X, o_Car_2X, o_Car_3X, o_Car_4X, o_Car_5X, o_Car_6X,
        output o_Reverse, o_State
    );

endinterface

// File: rtl/car_motion_controller_lane.sv
// One traffic lane: frame prescaler, direction bit and one or two car X positions.
// With CAR_MOTION_LANE_FLIP_EN defined the direction toggles whenever the lead car wraps.
module car_lane
    import car_motion_controller_pkg::*;
#(
    parameter logic [2:0] BASE_PERIOD = 3'd2,
    parameter bit         DUAL        = 1'b1,
    parameter bit         DIR_INIT    = 1'b1,
    parameter logic [9:0] INIT_A      = 10'd0,
    parameter logic [9:0] INIT_B      = 10'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init_i,
    input  logic       adv_i,
    input  logic [1:0] level_i,
    output logic [9:0] pos_a_o,
    output logic [9:0] pos_b_o,
    output logic       dir_o,
    output logic       step_o,
    output logic       wrap_o
);

    localparam logic [9:0] INIT_B_EFF = DUAL ? INIT_B : 10'd0;

    logic [2:0] cnt_q, cnt_d;
    logic [9:0] pos_a_q, pos_a_d;
    logic [9:0] pos_b_q, pos_b_d;
    logic       dir_q, dir_d;
    logic [2:0] period;
    logic [3:0] cnt_inc;

    // Period is re-evaluated every tick, so a lowered period catches up immediately
    assign period  = lane_period(BASE_PERIOD, level_i);
    assign cnt_inc = {1'b0, cnt_q} + 4'd1;
    assign step_o  = adv_i && (cnt_inc >= {1'b0, period});
    assign wrap_o  = step_o && crosses_edge(pos_a_q, dir_q);

    always_comb begin
        cnt_d   = cnt_q;
        pos_a_d = pos_a_q;
        pos_b_d = pos_b_q;
        dir_d   = dir_q;
        if (init_i) begin
            cnt_d   = 3'd0;
            pos_a_d = INIT_A;
            pos_b_d = INIT_B_EFF;
            dir_d   = DIR_INIT;
        end else if (adv_i) begin
            cnt_d = step_o ? 3'd0 : cnt_inc[2:0];
            if (step_o) begin
                pos_a_d = next_x(pos_a_q, dir_q);
                if (DUAL) pos_b_d = next_x(pos_b_q, dir_q);
`ifdef CAR_MOTION_LANE_FLIP_EN
                dir_d = dir_q ^ wrap_o;
`else
                dir_d = dir_q;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 3'd0;
            pos_a_q <= INIT_A;
            pos_b_q <= INIT_B_EFF;
            dir_q   <= DIR_INIT;
        end else begin
            cnt_q   <= cnt_d;
            pos_a_q <= pos_a_d;
            pos_b_q <= pos_b_d;
            dir_q   <= dir_d;
        end
    end

    assign pos_a_o = pos_a_q;
    assign pos_b_o = pos_b_q;
    assign dir_o   = dir_q;

endmodule

// File: rtl/car_motion_controller.sv
// Car motion controller: run/pause FSM, registered frame tick at start of vertical blank, four lanes.
// Define CAR_MOTION_LANE_FLIP_EN to make lanes reverse when their lead car wraps.
module car_motion_controller
    import car_motion_controller_pkg::*;
(
    input  logic                     i_Clk,
    input  logic                     i_Rst_N,
    car_motion_controller_if.slave   bus
);

    state_t state_q, state_d;
    logic   tick_q, tick_d;
    logic   match, adv, init;

    logic [9:0] l0_a, l0_b, l1_a, l1_b, l2_a, l2_b, l3_a, l3_b;
    logic [3:0] dir, step, wrap;

    assign match = (bus.i_H_Counter == 10'd0) && (bus.i_V_Counter == V_TICK_LINE);
    // Pause is checked directly so a pause coinciding with a tick already blocks the step
    assign adv   = match && (state_q == S_RUN) && !bus.i_Pause;
    assign init  = (state_q == S_INIT);

    always_comb begin
        state_d = state_q;
        tick_d  = match && (state_q != S_INIT);
        case (state_q)
            S_INIT:  state_d = S_RUN;
            S_RUN:   if (bus.i_Pause) state_d = S_PAUSE;
            S_PAUSE: if (!bus.i_Pause) state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            state_q <= S_INIT;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
        end
    end

    car_lane #(.BASE_PERIOD(BASE_PERIOD_L0), .DUAL(1'b1), .DIR_INIT(LANE_DIR[0]),
               .INIT_A(C1_INIT), .INIT_B(C5_INIT)) u_lane0 (
        .clk(i_Clk), .rst_n(i_Rst_N), .init_i(init), .adv_i(adv), .level_i(bus.i_Level),
        .pos_a_o(l0_a), .pos_b_o(l0_b), .dir_o(dir[0]), .step_o(step[0]), .wrap_o(wrap[0])
    );

    car_lane #(.BASE_PERIOD(BASE_PERIOD_L1), .DUAL(1'b1), .DIR_INIT(LANE_DIR[1]),
               .INIT_A(C2_INIT), .INIT_B(C6_INIT)) u_lane1 (
        .clk(i_Clk), .rst_n(i_Rst_N), .init_i(init), .adv_i(adv), .level_i(bus.i_Level),
        .pos_a_o(l1_a), .pos_b_o(l1_b), .dir_o(dir[1]), .step_o(step[1]), .wrap_o(wrap[1])
    );

    car_lane #(.BASE_PERIOD(BASE_PERIOD_L2), .DUAL(1'b0), .DIR_INIT(LANE_DIR[2]),
               .INIT_A(C3_INIT), .INIT_B(10'd0)) u_lane2 (
        .clk(i_Clk), .rst_n(i_Rst_N), .init_i(init), .adv_i(adv), .level_i(bus.i_Level),
        .pos_a_o(l2_a), .pos_b_o(l2_b), .dir_o(dir[2]), .step_o(step[2]), .wrap_o(wrap[2])
    );

    car_lane #(.BASE_PERIOD(BASE_PERIOD_L3), .DUAL(1'b0), .DIR_INIT(LANE_DIR[3]),
               .INIT_A(C4_INIT), .INIT_B(10'd0)) u_lane3 (
        .clk(i_Clk), .rst_n(i_Rst_N), .init_i(init), .adv_i(adv), .level_i(bus.i_Level),
        .pos_a_o(l3_a), .pos_b_o(l3_b), .dir_o(dir[3]), .step_o(step[3]), .wrap_o(wrap[3])
    );

    logic unused_lane_bits;
    assign unused_lane_bits = ^{l2_b, l3_b, step, wrap};

    assign bus.o_Frame_Tick = tick_q;
    assign bus.o_Car_1X     = l0_a;
    assign bus.o_Car_5X     = l0_b;
    assign bus.o_Car_2X     = l1_a;
    assign bus.o_Car_6X     = l1_b;
    assign bus.o_Car_3X     = l2_a;
    assign bus.o_Car_4X     = l3_a;
    assign bus.o_Reverse    = dir;
    assign bus.o_State      = state_q;

endmodule

// File: tb/tb_car_motion_controller.sv
// Directed plus randomized bench for car_motion_controller against a frame-level motion model.
// Honours CAR_MOTION_LANE_FLIP_EN in its model when the macro is defined for the build.
module tb_car_motion_controller;
    import car_motion_controller_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    car_motion_controller_if bus();

    car_motion_controller dut (
        .i_Clk   (clk),
        .i_Rst_N (rst_n),
        .bus     (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int mx[6];
    int mdir[4];
    int since[4];
    int car_lane_map[6] = '{0, 1, 2, 3, 0, 1};
    int base_p[4]       = '{2, 3, 4, 6};
    int init_x[6]       = '{0, 64, 128, 256, 320, 384};
    int lane_dir0[4]    = '{1, 0, 1, 0};
    bit wrap0_seen;
    logic [9:0] exp_q[$];

    task automatic model_reset();
        for (int c = 0; c < 6; c++) mx[c] = init_x[c];
        for (int l = 0; l < 4; l++) begin
            mdir[l]  = lane_dir0[l];
            since[l] = 0;
        end
    endtask

    task automatic model_step_lane(input int l);
        bit lead_wrap;
        int old;
        lead_wrap = 0;
        for (int c = 0; c < 6; c++) begin
            if (car_lane_map[c] == l) begin
                old   = mx[c];
                mx[c] = (mdir[l] != 0) ? (old + STEP_PX) % H_VISIBLE_AREA
                                       : (old + H_VISIBLE_AREA - STEP_PX) % H_VISIBLE_AREA;
                if (c == l && ((mdir[l] != 0) ? (mx[c] < old) : (mx[c] > old))) lead_wrap = 1;
            end
        end
        if (l == 0 && lead_wrap) wrap0_seen = 1;
`ifdef CAR_MOTION_LANE_FLIP_EN
        if (lead_wrap) mdir[l] = 1 - mdir[l];
`endif
    endtask

    // One frame in the model: each lane accumulates frames and moves once its period elapses
    task automatic model_frame(input bit paused, input int level);
        int p;
        if (paused) return;
        for (int l = 0; l < 4; l++) begin
            p = base_p[l] - level;
            if (p < 1) p = 1;
            since[l]++;
            if (since[l] >= p) begin
                since[l] = 0;
                model_step_lane(l);
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] dut_car(input int c);
        case (c)
            0: return bus.o_Car_1X;
            1: return bus.o_Car_2X;
            2: return bus.o_Car_3X;
            3: return bus.o_Car_4X;
            4: return bus.o_Car_5X;
            default: return bus.o_Car_6X;
        endcase
    endfunction

    task automatic check_cars(input string tag);
        logic [9:0] e;
        logic [3:0] rev;
        for (int c = 0; c < 6; c++) exp_q.push_back(10'(mx[c]));
        for (int c = 0; c < 6; c++) begin
            e = exp_q.pop_front();
            check($sformatf("%s_car%0d", tag, c + 1), 32'(dut_car(c)), 32'(e));
        end
        rev = {mdir[3] != 0, mdir[2] != 0, mdir[1] != 0, mdir[0] != 0};
        check({tag, "_reverse"}, 32'(bus.o_Reverse), 32'(rev));
    endtask

    // ---------------- drivers ----------------
    task automatic apply_reset();
        @(posedge clk);
        #1;
        bus.i_H_Counter = 10'd100;
        bus.i_V_Counter = 10'd200;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_cars("rst");
        check("rst_tick", 32'(bus.o_Frame_Tick), 32'd0);
        check("rst_state", 32'(bus.o_State), 32'(S_INIT));
        repeat (2) @(posedge clk);
        #1;
        // Release with the tick condition present: no tick may come out of S_INIT
        bus.i_H_Counter = 10'd0;
        bus.i_V_Counter = 10'(V_VISIBLE_AREA);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.i_H_Counter = 10'd1;
        check("init_no_tick", 32'(bus.o_Frame_Tick), 32'd0);
        check("init_state", 32'(bus.o_State), 32'(S_RUN));
        check_cars("init");
    endtask

    task automatic send_tick(input bit pause, input int level, input string tag);
        @(posedge clk);
        #1;
        bus.i_H_Counter = 10'd5;
        bus.i_V_Counter = 10'd100;
        bus.i_Pause     = pause;
        bus.i_Level     = 2'(level);
        @(posedge clk);
        #1;
        bus.i_H_Counter = 10'd0;
        bus.i_V_Counter = 10'(V_VISIBLE_AREA);
        @(posedge clk);
        #1;
        bus.i_H_Counter = 10'd1;
        check({tag, "_tick_hi"}, 32'(bus.o_Frame_Tick), 32'd1);
        model_frame(pause, level);
        check_cars(tag);
        @(posedge clk);
        #1;
        check({tag, "_tick_lo"}, 32'(bus.o_Frame_Tick), 32'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int t;
        checks      = 0;
        failures    = 0;
        wrap0_seen  = 0;
        rst_n       = 1'b0;
        bus.i_H_Counter = 10'd100;
        bus.i_V_Counter = 10'd200;
        bus.i_Level = 2'd0;
        bus.i_Pause = 1'b0;
        model_reset();

        apply_reset();

        // Lane 0 at level 0 steps every second frame
        send_tick(0, 0, "lvl0_a");
        check("lvl0_c1_hold", 32'(bus.o_Car_1X), 32'd0);
        send_tick(0, 0, "lvl0_b");
        check("lvl0_c1_step", 32'(bus.o_Car_1X), 32'd2);
        check("lvl0_c5_step", 32'(bus.o_Car_5X), 32'd322);
        for (int i = 0; i < 4; i++) send_tick(0, 0, "lvl0_run");

        // Pause held over ten frames
        @(posedge clk);
        #1;
        bus.i_Pause = 1'b1;
        @(posedge clk);
        #1;
        check("pause_state", 32'(bus.o_State), 32'(S_PAUSE));
        for (int i = 0; i < 10; i++) send_tick(1, 0, "pause");
        for (int i = 0; i < 3; i++) send_tick(0, 0, "resume");

        // Level 3: drive lane 0 around until its lead car wraps
        wrap0_seen = 0;
        t = 0;
        while (t < 400 && !wrap0_seen) begin
            send_tick(0, 3, "lvl3");
            t++;
        end
        check("wrap_seen", 32'(wrap0_seen), 32'd1);
        check("wrap_c1", 32'(bus.o_Car_1X), 32'd0);
`ifdef CAR_MOTION_LANE_FLIP_EN
        check("wrap_rev0", 32'(bus.o_Reverse[0]), 32'd0);
`else
        check("wrap_rev0", 32'(bus.o_Reverse[0]), 32'd1);
`endif
        send_tick(0, 3, "post_wrap");
`ifdef CAR_MOTION_LANE_FLIP_EN
        check("post_wrap_c1", 32'(bus.o_Car_1X), 32'd638);
`else
        check("post_wrap_c1", 32'(bus.o_Car_1X), 32'd2);
`endif

        // Randomized frames with level changes and occasional pause
        for (int i = 0; i < 200; i++) begin
            send_tick($urandom_range(0, 4) == 0, int'($urandom_range(0, 3)), "rand");
        end

        // Reset in the middle of a frame, then confirm motion restarts from init
        apply_reset();
        for (int i = 0; i < 6; i++) send_tick(0, int'($urandom_range(0, 3)), "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
